// File: rtl/adder_serial_n.sv
// Bit-serial unsigned adder: one full-adder cell plus a carry flop, LSB first, start/done handshake.
// Optional signed-overflow output is enabled by defining ADDER_SERIAL_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start_i; operands latched on the accepting edge
// RUN   | one sum bit per clock, nb_bit clocks
// DONE  | single-cycle done_o pulse, results held
module adder_serial_n #(
  parameter int nb_bit = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [nb_bit-1:0] sum_o,
  output logic              carry_o
`ifdef ADDER_SERIAL_OVF_EN
  ,
  output logic              ovf_o
`endif
);

  localparam int cw = $clog2(nb_bit);
  localparam logic [cw-1:0] last_cnt = cw'(nb_bit - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [nb_bit-1:0] a_sh;
  logic [nb_bit-1:0] b_sh;
  logic [nb_bit-1:0] sum_sh;
  logic              carry;
  logic [cw-1:0]     cnt;
  logic              s_bit;
  logic              c_next;

  always_comb begin
    s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
    c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sum_o   <= '0;
      carry_o <= 1'b0;
`ifdef ADDER_SERIAL_OVF_EN
      ovf_o   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_sh   <= a_i;
            b_sh   <= b_i;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {s_bit, sum_sh[nb_bit-1:1]};
          carry  <= c_next;
          cnt    <= cnt + 1'b1;
          if (cnt == last_cnt) begin
            sum_o   <= {s_bit, sum_sh[nb_bit-1:1]};
            carry_o <= c_next;
`ifdef ADDER_SERIAL_OVF_EN
            // On the last step a_sh[0]/b_sh[0] are the operand MSBs and s_bit is the sum MSB.
            ovf_o   <= (a_sh[0] == b_sh[0]) && (s_bit != a_sh[0]);
`endif
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_serial_n.sv
// Self-checking bench for adder_serial_n (nb_bit = 8): directed cases, reset aborts, corner sweep and random pairs.
// Define ADDER_SERIAL_OVF_EN for both files to also check ovf_o.
module tb_adder_serial_n;
  localparam int NB = 8;

  typedef struct {
    logic [NB:0] full;
    logic        ovf;
  } exp_t;

  logic          clk_i   = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic [NB-1:0] a_i     = '0;
  logic [NB-1:0] b_i     = '0;
  logic          busy_o;
  logic          done_o;
  logic [NB-1:0] sum_o;
  logic          carry_o;
`ifdef ADDER_SERIAL_OVF_EN
  logic          ovf_o;
`endif

  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];

  adder_serial_n #(.nb_bit(NB)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .carry_o (carry_o)
`ifdef ADDER_SERIAL_OVF_EN
    ,
    .ovf_o   (ovf_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic ref_ovf(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int sa, sbv, s;
    sa  = a[NB-1] ? int'(a) - (1 << NB) : int'(a);
    sbv = b[NB-1] ? int'(b) - (1 << NB) : int'(b);
    s   = sa + sbv;
    return (s > (1 << (NB - 1)) - 1) || (s < -(1 << (NB - 1)));
  endfunction

  task automatic push_exp(input logic [NB-1:0] a, input logic [NB-1:0] b);
    exp_t e;
    e.full = {1'b0, a} + {1'b0, b};
    e.ovf  = ref_ovf(a, b);
    sb.push_back(e);
  endtask

  // Samples at negedges; n_exp is the index of the negedge (counting from the first one after the call) on which done_o must be seen.
  task automatic wait_done(input int n_exp);
    int   n    = 0;
    bit   seen = 1'b0;
    exp_t e;
    while (n < 3 * NB && !seen) begin
      @(negedge clk_i);
      n++;
      check("busy_done_excl", 32'(busy_o & done_o), 32'd0);
      if (done_o) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) check("latency", n, n_exp);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (seen) begin
        check("sum_carry", 32'({carry_o, sum_o}), 32'(e.full));
`ifdef ADDER_SERIAL_OVF_EN
        check("ovf", 32'(ovf_o), 32'(e.ovf));
`endif
      end
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
  task automatic do_op(input logic [NB-1:0] a, input logic [NB-1:0] b);
    push_exp(a, b);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    a_i = ~a;
    b_i = ~b;
    // first negedge sample lies before E1, so done (after E_NB) shows on sample NB+1
    wait_done(NB + 1);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  logic [NB-1:0] corners [16];
  bit            seen_abort;

  initial begin
    corners = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h3F, 8'h40, 8'h55, 8'h7E,
                8'h7F, 8'h80, 8'h81, 8'hAA, 8'hBF, 8'hC0, 8'hFE, 8'hFF};

    #2;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_sum", 32'(sum_o), 32'd0);
    check("rst_carry", 32'(carry_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    do_op(8'h3C, 8'h05);
    do_op(8'hFF, 8'h01);
    do_op(8'h7F, 8'h01);

    // start held high through RUN with changed operands
    push_exp(8'h10, 8'h20);
    a_i = 8'h10;
    b_i = 8'h20;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    a_i = 8'hAA;
    wait_done(NB + 1);
    push_exp(8'hAA, 8'h20);
    @(negedge clk_i);
    check("held_idle_e9", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    check("held_accept_e10", 32'(busy_o), 32'd1);
    start_i = 1'b0;
    wait_done(NB);
    @(posedge clk_i);
    @(negedge clk_i);

    // asynchronous reset mid-cycle during RUN
    do_op(8'hFF, 8'h01);
    a_i = 8'h11;
    b_i = 8'h22;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #3;
    rst_n_i = 1'b0;
    #1;
    check("async_busy", 32'(busy_o), 32'd0);
    check("async_sum", 32'(sum_o), 32'd0);
    check("async_carry", 32'(carry_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("async_idle", 32'(busy_o), 32'd0);

    // reset at E4 of an operation
    do_op(8'h7F, 8'h01);
    a_i = 8'h12;
    b_i = 8'h34;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    rst_n_i = 1'b0;
    #1;
    check("abort_sum", 32'(sum_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    seen_abort = 1'b0;
    repeat (2 * NB) begin
      @(negedge clk_i);
      if (done_o) seen_abort = 1'b1;
    end
    check("abort_no_done", 32'(seen_abort), 32'd0);
    check("abort_carry", 32'(carry_o), 32'd0);
    do_op(8'h3C, 8'h05);

    foreach (corners[i]) foreach (corners[j]) do_op(corners[i], corners[j]);
    repeat (2500) do_op(NB'($urandom_range(0, 255)), NB'($urandom_range(0, 255)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
